// File: rtl/i2c_regfile_ctrl_pkg.sv
// Shared types for the I2C register-file controller: FSM states and default DVL register indices.
package dvl_i2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PTR   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } i2c_ctrl_state_t;

    localparam int REG_CTRL   = 0;
    localparam int REG_GAIN   = 1;
    localparam int REG_STATUS = 4;

    localparam logic [7:0] RD_ERR_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_regfile_ctrl_if.sv
// Byte-level handshake between the I2C peripheral (master) and the register-file controller (slave).
interface i2c_regfile_ctrl_if;
    logic       start;
    logic       stop;
    logic       rw;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (
        output start, stop, rw, rx_valid, rx_data, tx_req,
        input  tx_data, tx_valid
    );

    modport slave (
        input  start, stop, rw, rx_valid, rx_data, tx_req,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/i2c_regfile_ctrl_regbank.sv
// Register bank: one write port and a combinational read mux; read-only slots read hw_status and hold 0.
module i2c_regbank #(
    parameter int                      NUM_REGS  = 8,
    parameter int                      AW        = 3,
    parameter logic [NUM_REGS-1:0]     WR_MASK   = NUM_REGS'(8'h0F),
    parameter logic [8*NUM_REGS-1:0]   RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic [AW-1:0]              rd_addr,
    input  logic [NUM_REGS-1:0][7:0]   hw_status,
    output logic [7:0]                 rd_data,
    output logic [NUM_REGS-1:0][7:0]   regs
);

    logic [NUM_REGS-1:0][7:0] regs_d, regs_q;

    always_comb begin
        regs_d = regs_q;
        if (wr_en && WR_MASK[wr_addr]) regs_d[wr_addr] = wr_data;
    end

    // Read-only slots reset to 0 and are never written, so they stay constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= WR_MASK[i] ? RESET_VAL[8*i +: 8] : 8'h00;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data = WR_MASK[rd_addr] ? regs_q[rd_addr] : hw_status[rd_addr];
    assign regs    = regs_q;

endmodule

// File: rtl/i2c_regfile_ctrl.sv
// I2C register-map sequencer: pointer byte, auto-incrementing writes and reads into i2c_regbank.
module i2c_regfile_ctrl
    import dvl_i2c_pkg::*;
#(
    parameter int                      NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0]     WR_MASK   = NUM_REGS'(8'h0F),
    parameter logic [8*NUM_REGS-1:0]   RESET_VAL = '0,
    localparam int                     AW        = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    i2c_regfile_ctrl_if.slave          bus,
    input  logic [NUM_REGS-1:0][7:0]   hw_status,
    output logic [NUM_REGS-1:0][7:0]   cfg,
    output logic                       wr_strobe,
    output logic [AW-1:0]              wr_addr,
    output logic                       ptr_err
);

    i2c_ctrl_state_t state_d, state_q;
    logic [AW-1:0]   ptr_d, ptr_q;
    logic            ptr_err_d, ptr_err_q;
    logic [7:0]      tx_data_d, tx_data_q;
    logic            tx_valid_d, tx_valid_q;
    logic            wr_strobe_d, wr_strobe_q;
    logic [AW-1:0]   wr_addr_d, wr_addr_q;
    logic            bank_we;
    logic [7:0]      bank_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (int'(p) == NUM_REGS - 1) ? '0 : p + AW'(1);
    endfunction

    i2c_regbank #(
        .NUM_REGS  (NUM_REGS),
        .AW        (AW),
        .WR_MASK   (WR_MASK),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bank_we),
        .wr_addr   (ptr_q),
        .wr_data   (bus.rx_data),
        .rd_addr   (ptr_q),
        .hw_status (hw_status),
        .rd_data   (bank_rd),
        .regs      (cfg)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ptr_err_d   = ptr_err_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        bank_we     = 1'b0;

        case (state_q)
            PTR: if (bus.rx_valid) begin
                if (int'(bus.rx_data) < NUM_REGS) begin
                    ptr_d     = bus.rx_data[AW-1:0];
                    ptr_err_d = 1'b0;
                end else begin
                    ptr_err_d = 1'b1;
                end
                state_d = WDATA;
            end
            WDATA: if (bus.rx_valid) begin
                if (WR_MASK[ptr_q] && !ptr_err_q) begin
                    bank_we     = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = ptr_q;
                end
                ptr_d = ptr_inc(ptr_q);
            end
            RDATA: if (bus.tx_req) begin
                tx_valid_d = 1'b1;
                tx_data_d  = ptr_err_q ? RD_ERR_BYTE : bank_rd;
                if (!ptr_err_q) ptr_d = ptr_inc(ptr_q);
            end
            default: ;
        endcase

        // Byte in flight is handled above first; start overrides a coincident stop.
        if (bus.stop)  state_d = IDLE;
        if (bus.start) state_d = bus.rw ? RDATA : PTR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            ptr_err_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ptr_err_q   <= ptr_err_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign wr_strobe    = wr_strobe_q;
    assign wr_addr      = wr_addr_q;
    assign ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// Bench for i2c_regfile_ctrl: two instances (mask 0F / reset 0, mask FF / nonzero reset) against a register-map model.
module tb_i2c_regfile_ctrl;

    localparam logic [7:0]  MASK_A = 8'h0F;
    localparam logic [7:0]  MASK_B = 8'hFF;
    localparam logic [63:0] RV_B   = 64'h8877665544332211;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 0, stop = 0, rw = 0, rx_valid = 0, tx_req = 0;
    logic [7:0] rx_data = 0;
    logic [7:0][7:0] hw_status = '0;

    i2c_regfile_ctrl_if ia();
    i2c_regfile_ctrl_if ib();
    assign ia.start = start;    assign ib.start = start;
    assign ia.stop = stop;      assign ib.stop = stop;
    assign ia.rw = rw;          assign ib.rw = rw;
    assign ia.rx_valid = rx_valid; assign ib.rx_valid = rx_valid;
    assign ia.rx_data = rx_data;   assign ib.rx_data = rx_data;
    assign ia.tx_req = tx_req;     assign ib.tx_req = tx_req;

    logic [7:0][7:0] ca, cb;
    logic            sa, sb, ea, eb;
    logic [2:0]      wa, wb;

    i2c_regfile_ctrl #(.NUM_REGS(8), .WR_MASK(MASK_A), .RESET_VAL(64'h0)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave), .hw_status(hw_status),
        .cfg(ca), .wr_strobe(sa), .wr_addr(wa), .ptr_err(ea));

    i2c_regfile_ctrl #(.NUM_REGS(8), .WR_MASK(MASK_B), .RESET_VAL(RV_B)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave), .hw_status(hw_status),
        .cfg(cb), .wr_strobe(sb), .wr_addr(wb), .ptr_err(eb));

    int n_chk = 0;
    int n_fail = 0;

    // Model: per instance, register contents, pointer, error flag and transaction phase.
    typedef enum int {M_IDLE, M_AWAIT_PTR, M_WRITING, M_READING} phase_t;
    logic [7:0] mreg [2][8];
    int         mptr [2];
    bit         merr [2];
    phase_t     mph  [2];

    function automatic bit writable(input int m, input int i);
        logic [7:0] mk;
        mk = (m == 0) ? MASK_A : MASK_B;
        return mk[i];
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++)
                mreg[m][i] = (m == 1 && writable(m, i)) ? RV_B[8*i +: 8] : 8'h00;
            mptr[m] = 0;
            merr[m] = 0;
            mph[m]  = M_IDLE;
        end
    endtask

    // Drive one clock of stimulus (called at a falling edge), advance the model, compare every output.
    task automatic cycle(input bit s_st, input bit s_sp, input bit s_rw,
                         input bit s_rxv, input logic [7:0] s_rxd, input bit s_txr);
        bit es [2]; int eadr [2]; bit ev [2]; logic [7:0] ed [2];
        logic os, ov, oe; logic [2:0] oa; logic [7:0] od; logic [7:0][7:0] oc, ec;
        start = s_st; stop = s_sp; rw = s_rw; rx_valid = s_rxv; rx_data = s_rxd; tx_req = s_txr;
        for (int m = 0; m < 2; m++) begin
            es[m] = 0; ev[m] = 0; eadr[m] = 0; ed[m] = 8'h00;
            if (mph[m] == M_AWAIT_PTR && s_rxv) begin
                if (s_rxd < 8) begin mptr[m] = int'(s_rxd); merr[m] = 0; end
                else merr[m] = 1;
                mph[m] = M_WRITING;
            end else if (mph[m] == M_WRITING && s_rxv) begin
                if (writable(m, mptr[m]) && !merr[m]) begin
                    mreg[m][mptr[m]] = s_rxd; es[m] = 1; eadr[m] = mptr[m];
                end
                mptr[m] = (mptr[m] + 1) % 8;
            end else if (mph[m] == M_READING && s_txr) begin
                ev[m] = 1;
                if (merr[m]) ed[m] = 8'hFF;
                else begin
                    ed[m] = writable(m, mptr[m]) ? mreg[m][mptr[m]] : hw_status[mptr[m]];
                    mptr[m] = (mptr[m] + 1) % 8;
                end
            end
            if (s_sp) mph[m] = M_IDLE;
            if (s_st) mph[m] = s_rw ? M_READING : M_AWAIT_PTR;
        end
        @(negedge clk);
        start = 0; stop = 0; rw = 0; rx_valid = 0; tx_req = 0;
        for (int m = 0; m < 2; m++) begin
            os = (m == 0) ? sa : sb;
            oa = (m == 0) ? wa : wb;
            ov = (m == 0) ? ia.tx_valid : ib.tx_valid;
            od = (m == 0) ? ia.tx_data : ib.tx_data;
            oe = (m == 0) ? ea : eb;
            oc = (m == 0) ? ca : cb;
            for (int i = 0; i < 8; i++) ec[i] = mreg[m][i];
            n_chk++;
            if (os !== es[m]) begin
                n_fail++; $display("FAIL wr_strobe dut%0d t=%0t: got %b want %b", m, $time, os, es[m]);
            end
            if (es[m]) begin
                n_chk++;
                if (oa !== 3'(eadr[m])) begin
                    n_fail++; $display("FAIL wr_addr dut%0d t=%0t: got %0d want %0d", m, $time, oa, eadr[m]);
                end
            end
            n_chk++;
            if (ov !== ev[m]) begin
                n_fail++; $display("FAIL tx_valid dut%0d t=%0t: got %b want %b", m, $time, ov, ev[m]);
            end
            if (ev[m]) begin
                n_chk++;
                if (od !== ed[m]) begin
                    n_fail++; $display("FAIL tx_data dut%0d t=%0t: got %h want %h", m, $time, od, ed[m]);
                end
            end
            n_chk++;
            if (oe !== merr[m]) begin
                n_fail++; $display("FAIL ptr_err dut%0d t=%0t: got %b want %b", m, $time, oe, merr[m]);
            end
            n_chk++;
            if (oc !== ec) begin
                n_fail++; $display("FAIL cfg dut%0d t=%0t: got %h want %h", m, $time, oc, ec);
            end
        end
    endtask

    task automatic test_reset();
        m_reset();
        n_chk++;
        if (ca !== 64'h0 || cb !== RV_B) begin
            n_fail++; $display("FAIL reset_cfg: got %h / %h want 0 / %h", ca, cb, RV_B);
        end
        n_chk++;
        if ({sa, sb, ea, eb, ia.tx_valid, ib.tx_valid, wa, wb, ia.tx_data, ib.tx_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %b %b %b %b %b %b %0d %0d %h %h want all 0",
                               sa, sb, ea, eb, ia.tx_valid, ib.tx_valid, wa, wb, ia.tx_data, ib.tx_data);
        end
    endtask

    task automatic test_write_incr();
        cycle(1, 0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 1, 8'h02, 0);
        cycle(0, 0, 0, 1, 8'hA5, 0);
        n_chk++;
        if (ca[2] !== 8'hA5 || sa !== 1'b1 || wa !== 3'd2) begin
            n_fail++; $display("FAIL write_reg2: got %h/%b/%0d want a5/1/2", ca[2], sa, wa);
        end
        cycle(0, 0, 0, 1, 8'h3C, 0);
        n_chk++;
        if (ca[3] !== 8'h3C || wa !== 3'd3) begin
            n_fail++; $display("FAIL write_reg3: got %h/%0d want 3c/3", ca[3], wa);
        end
        cycle(0, 1, 0, 0, 8'h00, 0);
    endtask

    task automatic test_wrap();
        cycle(1, 0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 1, 8'h07, 0);
        cycle(0, 0, 0, 1, 8'h11, 0);
        cycle(0, 0, 0, 1, 8'h22, 0);
        n_chk++;
        if (cb[7] !== 8'h11 || cb[0] !== 8'h22) begin
            n_fail++; $display("FAIL wrap: got reg7=%h reg0=%h want 11/22", cb[7], cb[0]);
        end
        cycle(0, 1, 0, 0, 8'h00, 0);
    endtask

    task automatic test_read_status();
        logic [7:0] want [3];
        want[0] = 8'h10; want[1] = 8'h20; want[2] = 8'h30;
        hw_status[4] = 8'h10; hw_status[5] = 8'h20; hw_status[6] = 8'h30;
        cycle(1, 0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 1, 8'h04, 0);
        cycle(1, 0, 1, 0, 8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 8'h00, 1);
            n_chk++;
            if (ia.tx_data !== want[k] || ia.tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL read_status%0d: got %h/%b want %h/1", k, ia.tx_data, ia.tx_valid, want[k]);
            end
            cycle(0, 0, 0, 0, 8'h00, 0);
        end
        cycle(0, 1, 0, 0, 8'h00, 0);
    endtask

    task automatic test_readonly_drop();
        cycle(1, 0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 1, 8'h04, 0);
        cycle(0, 0, 0, 1, 8'hEE, 0);
        n_chk++;
        if (sa !== 1'b0 || ca[4] !== 8'h00) begin
            n_fail++; $display("FAIL ro_drop: got strobe %b slot4 %h want 0/00", sa, ca[4]);
        end
        hw_status[5] = 8'h5B;
        cycle(1, 0, 1, 0, 8'h00, 0);
        cycle(0, 0, 0, 0, 8'h00, 1);
        n_chk++;
        if (ia.tx_data !== 8'h5B) begin
            n_fail++; $display("FAIL ro_ptr_adv: got %h want 5b", ia.tx_data);
        end
        cycle(0, 1, 0, 0, 8'h00, 0);
    endtask

    task automatic test_ptr_err();
        cycle(1, 0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 1, 8'h09, 0);
        n_chk++;
        if (ea !== 1'b1 || eb !== 1'b1) begin
            n_fail++; $display("FAIL ptr_err_set: got %b/%b want 1/1", ea, eb);
        end
        cycle(0, 0, 0, 1, 8'h5A, 0);
        cycle(1, 0, 1, 0, 8'h00, 0);
        cycle(0, 0, 0, 0, 8'h00, 1);
        n_chk++;
        if (ia.tx_data !== 8'hFF || ib.tx_data !== 8'hFF) begin
            n_fail++; $display("FAIL ptr_err_read: got %h/%h want ff/ff", ia.tx_data, ib.tx_data);
        end
        cycle(0, 0, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 1, 8'h01, 0);
        n_chk++;
        if (ea !== 1'b0) begin
            n_fail++; $display("FAIL ptr_err_clear: got %b want 0", ea);
        end
        cycle(0, 1, 0, 0, 8'h00, 0);
    endtask

    task automatic test_rst_mid();
        cycle(1, 0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 1, 8'h01, 0);
        cycle(0, 0, 0, 1, 8'h55, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (ca !== 64'h0 || cb !== RV_B || sa !== 1'b0 || wa !== 3'd0 || ea !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: got %h / %h strobe %b addr %0d err %b want reset values",
                               ca, cb, sa, wa, ea);
        end
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0, 1, 8'h77, 0);
        cycle(0, 0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) hw_status = {$urandom, $urandom};
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, 1'($urandom),
                  1'($urandom), 8'($urandom_range(0, 11)), 1'($urandom));
        end
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_write_incr();
        test_wrap();
        test_read_status();
        test_readonly_drop();
        test_ptr_err();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
